// File: rtl/ev_cs_auth_engine.sv
// -----------------------------------------------------------------------------
// ev_cs_auth_engine
//   EV-side mutual authentication engine for an EV / charging-station session.
//   Exchanges four messages (M1 out, M2 in, M3 out, M4 in) over word streams,
//   checks the station's proof and reports success, or a failure with a cause.
//
// Ports
//   clk, rst_n        rising-edge clock, synchronous active-low reset
//   start             begin a session (ignored while busy)
//   ev_psid, ev_pub,
//   cs_pub, ev_rs     session inputs, latched on an accepted start
//   tx_valid/ready/
//   data/last         outgoing message stream, tx_last on final word
//   rx_valid/ready/
//   data/last         incoming message stream, rx_last on final word
//   busy              session in progress
//   auth_ok/auth_fail one-cycle result pulses
//   fail_code         0 none, 1 timeout, 2 verify, 3 framing (held to next start)
//   session_key       derived key (zero unless AUTH_SESSION_KEY_EN is defined)
//
// Configuration
//   AUTH_SESSION_KEY_EN  adds the KEY state and the session-key hash.
// -----------------------------------------------------------------------------
module ev_cs_auth_engine #(
    parameter int unsigned W           = 64,
    parameter int unsigned PUF_ROUNDS  = 64,
    parameter int unsigned TIMEOUT_CYC = 1024,
    parameter int unsigned MAX_RETRY   = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] ev_psid,
    input  logic [W-1:0] ev_pub,
    input  logic [W-1:0] cs_pub,
    input  logic [W-1:0] ev_rs,
    output logic         tx_valid,
    input  logic         tx_ready,
    output logic [W-1:0] tx_data,
    output logic         tx_last,
    input  logic         rx_valid,
    output logic         rx_ready,
    input  logic [W-1:0] rx_data,
    input  logic         rx_last,
    output logic         busy,
    output logic         auth_ok,
    output logic         auth_fail,
    output logic [1:0]   fail_code,
    output logic [W-1:0] session_key
);
    localparam int unsigned   TW        = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam int unsigned   RW        = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [TW-1:0] TOUT_LAST = TW'(TIMEOUT_CYC - 1);
    localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);
    localparam logic [1:0]    FC_TIMEOUT = 2'd1;
    localparam logic [1:0]    FC_VERIFY  = 2'd2;
    localparam logic [1:0]    FC_FRAMING = 2'd3;

    typedef enum logic [3:0] {
        IDLE, SEND_M1, WAIT_M2, SEND_M3, WAIT_M4, VERIFY, KEY, DONE, FAIL
    } state_t;

`ifdef AUTH_SESSION_KEY_EN
    localparam state_t PASS_STATE = KEY;
`else
    localparam state_t PASS_STATE = DONE;
`endif

    state_t        state, state_next;
    logic [W-1:0]  psid_q, evpub_q, cspub_q, evrs_q, n1;
    logic [W-1:0]  cs_id, ch_k, ki, cs_id4, ch_k4, rsk;
    logic [2:0]    idx;
    logic [TW-1:0] tout_cnt;
    logic [RW-1:0] retry_cnt;
    logic [1:0]    fail_cause;
    logic [W-1:0]  rx_word;
    logic          tx_fire, rx_fire, in_wait, at_last, tout_expire, verify_ok;

    // LFSR-based PUF model; linear, so it collapses to an XOR network.
    function automatic logic [W-1:0] puf(input logic [W-1:0] x_in);
        logic [W-1:0] x;
        x = x_in;
        for (int unsigned r = 0; r < PUF_ROUNDS; r++)
            x = {x[W-2:0], x[W-1] ^ x[W-2] ^ x[W-4] ^ x[W-5]};
        return x;
    endfunction

    assign tx_fire     = tx_valid & tx_ready;
    assign rx_fire     = rx_valid & rx_ready;
    assign in_wait     = (state == WAIT_M2) || (state == WAIT_M4);
    assign tout_expire = (tout_cnt == TOUT_LAST);
    assign rx_word     = rx_data ^ ((state == WAIT_M2) ? evpub_q : ki);
    assign verify_ok   = (rsk == puf(ch_k)) && (cs_id4 == cs_id) && (ch_k4 == ch_k);

    always_comb begin
        case (state)
            SEND_M1:          at_last = (idx == 3'd2);
            WAIT_M2:          at_last = (idx == 3'd3);
            SEND_M3, WAIT_M4: at_last = (idx == 3'd4);
            default:          at_last = 1'b0;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Next-state logic; an accepted word beats a coincident timeout.
    always_comb begin
        state_next = state;
        fail_cause = 2'd0;
        case (state)
            IDLE:    if (start) state_next = SEND_M1;
            SEND_M1: if (tx_fire && at_last) state_next = WAIT_M2;
            SEND_M3: if (tx_fire && at_last) state_next = WAIT_M4;
            WAIT_M2, WAIT_M4: begin
                if (rx_fire) begin
                    if (rx_last != at_last) begin
                        state_next = FAIL;
                        fail_cause = FC_FRAMING;
                    end else if (at_last) begin
                        state_next = (state == WAIT_M2) ? SEND_M3 : VERIFY;
                    end
                end else if (tout_expire) begin
                    if (retry_cnt < RETRY_MAX) begin
                        state_next = SEND_M1;
                    end else begin
                        state_next = FAIL;
                        fail_cause = FC_TIMEOUT;
                    end
                end
            end
            VERIFY: begin
                if (verify_ok) begin
                    state_next = PASS_STATE;
                end else begin
                    state_next = FAIL;
                    fail_cause = FC_VERIFY;
                end
            end
            KEY:       state_next = DONE;
            DONE, FAIL: state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        tx_valid  = 1'b0;
        tx_last   = 1'b0;
        tx_data   = '0;
        rx_ready  = in_wait;
        busy      = (state != IDLE);
        auth_ok   = (state == DONE);
        auth_fail = (state == FAIL);
        case (state)
            SEND_M1: begin
                tx_valid = 1'b1;
                tx_last  = at_last;
                case (idx)
                    3'd0:    tx_data = psid_q ^ cspub_q;
                    3'd1:    tx_data = n1 ^ cspub_q;
                    default: tx_data = evpub_q ^ cspub_q;
                endcase
            end
            SEND_M3: begin
                tx_valid = 1'b1;
                tx_last  = at_last;
                case (idx)
                    3'd0:       tx_data = psid_q ^ cspub_q;
                    3'd1, 3'd3: tx_data = ch_k ^ cspub_q;
                    3'd2:       tx_data = evrs_q ^ cspub_q;
                    default:    tx_data = ki ^ cspub_q;
                endcase
            end
            default: ;
        endcase
    end

    // Session datapath
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            psid_q <= '0; evpub_q <= '0; cspub_q <= '0; evrs_q <= '0; n1 <= '0;
            cs_id <= '0; ch_k <= '0; ki <= '0; cs_id4 <= '0; ch_k4 <= '0; rsk <= '0;
            idx <= '0; tout_cnt <= '0; retry_cnt <= '0; fail_code <= '0;
        end else begin
            if (state == IDLE && start) begin
                psid_q    <= ev_psid;
                evpub_q   <= ev_pub;
                cspub_q   <= cs_pub;
                evrs_q    <= ev_rs;
                n1        <= n1 + 1'b1;
                retry_cnt <= '0;
                fail_code <= '0;
            end else if (in_wait && state_next == SEND_M1) begin
                retry_cnt <= retry_cnt + 1'b1;
            end

            // Word index restarts on every state change, including retransmission.
            if (state_next != state)      idx <= '0;
            else if (tx_fire || rx_fire)  idx <= idx + 3'd1;

            if (!in_wait || rx_fire || state_next != state) tout_cnt <= '0;
            else                                            tout_cnt <= tout_cnt + 1'b1;

            if (rx_fire && state == WAIT_M2) begin
                case (idx)
                    3'd0:    cs_id <= rx_word;
                    3'd1:    ch_k  <= rx_word;
                    3'd3:    ki    <= puf(rx_word);
                    default: ;
                endcase
            end
            if (rx_fire && state == WAIT_M4) begin
                case (idx)
                    3'd0:    cs_id4 <= rx_word;
                    3'd1:    ch_k4  <= rx_word;
                    3'd3:    rsk    <= rx_word;
                    default: ;
                endcase
            end

            if (state != FAIL && state_next == FAIL) fail_code <= fail_cause;
        end
    end

`ifdef AUTH_SESSION_KEY_EN
    localparam logic [W-1:0] HASH_INIT = {(W/8){8'hA5}};
    localparam logic [W-1:0] HASH_MIX  = {(W/8){8'hC3}};

    logic [W-1:0] n2, n4, tk;

    function automatic logic [W-1:0] hash4(input logic [W-1:0] w0, w1, w2, w3);
        logic [W-1:0] s;
        logic [W-1:0] w [4];
        w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3;
        s = HASH_INIT;
        for (int unsigned i = 0; i < 4; i++) begin
            s = s ^ w[i];
            s = {s[W-4:0], s[W-1:W-3]} ^ (s >> 5) ^ (HASH_MIX >> (8 * (i % (W/8))));
        end
        return s;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            n2 <= '0; n4 <= '0; tk <= '0; session_key <= '0;
        end else begin
            if (rx_fire && state == WAIT_M2 && idx == 3'd2) n2 <= rx_word;
            if (rx_fire && state == WAIT_M4 && idx == 3'd2) n4 <= rx_word;
            if (rx_fire && state == WAIT_M4 && idx == 3'd4) tk <= rx_word;
            if (state == KEY) session_key <= hash4(ki, n2, n4, tk);
        end
    end
`else
    assign session_key = '0;
`endif

endmodule

// File: tb/tb_ev_cs_auth_engine.sv
// -----------------------------------------------------------------------------
// tb_ev_cs_auth_engine
//   Directed bench for ev_cs_auth_engine (W=64, TIMEOUT_CYC=16, MAX_RETRY=1).
//   Sessions: stalled M1 + full success, verify failure with a word accepted
//   on the timeout boundary, framing failure, timeout with one retry, and a
//   reset in the middle of WAIT_M2.
// -----------------------------------------------------------------------------
module tb_ev_cs_auth_engine;
    logic        clk = 1'b0;
    logic        rst_n, start;
    logic [63:0] ev_psid, ev_pub, cs_pub, ev_rs;
    logic        tx_valid, tx_ready, tx_last;
    logic [63:0] tx_data;
    logic        rx_valid, rx_ready, rx_last;
    logic [63:0] rx_data;
    logic        busy, auth_ok, auth_fail;
    logic [1:0]  fail_code;
    logic [63:0] session_key;

    always #5 clk = ~clk;

    ev_cs_auth_engine #(.W(64), .PUF_ROUNDS(64), .TIMEOUT_CYC(16), .MAX_RETRY(1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .ev_psid(ev_psid), .ev_pub(ev_pub), .cs_pub(cs_pub), .ev_rs(ev_rs),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data), .tx_last(tx_last),
        .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_data(rx_data), .rx_last(rx_last),
        .busy(busy), .auth_ok(auth_ok), .auth_fail(auth_fail),
        .fail_code(fail_code), .session_key(session_key)
    );

    int checks = 0;
    int failures = 0;
    int ok_cnt = 0;
    int fail_cnt = 0;
    logic [63:0] exp_w [5];
    logic [63:0] rx_w [5];
    logic        rx_l [5];
    logic [63:0] ki;
    int          cyc;
    int          ok_base, fail_base;

    always @(negedge clk) begin
        if (auth_ok)   ok_cnt++;
        if (auth_fail) fail_cnt++;
    end

    // Reference PUF: feedback as parity over the tap mask {63,62,60,59}.
    function automatic logic [63:0] puf_m(input logic [63:0] v);
        logic [63:0] x;
        x = v;
        for (int r = 0; r < 64; r++)
            x = (x << 1) | 64'(^(x & 64'hD800_0000_0000_0000));
        return x;
    endfunction

`ifdef AUTH_SESSION_KEY_EN
    function automatic logic [63:0] hash_m(input logic [63:0] a, b, c, d);
        logic [63:0] s;
        logic [63:0] w [4];
        w[0] = a; w[1] = b; w[2] = c; w[3] = d;
        s = 64'hA5A5_A5A5_A5A5_A5A5;
        for (int i = 0; i < 4; i++) begin
            s = s ^ w[i];
            s = ((s << 3) | (s >> 61)) ^ (s >> 5) ^ (64'hC3C3_C3C3_C3C3_C3C3 >> (8 * i));
        end
        return s;
    endfunction
    localparam int OK_LAT = 2;
`else
    localparam int OK_LAT = 1;
`endif

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_start;
        ev_psid = 64'h1234; ev_pub = 64'h5A5A; cs_pub = 64'hFF00; ev_rs = 64'h0BAD_F00D;
        start = 1'b1;
        tick;
        start = 1'b0;
    endtask

    task automatic recv_tx(input int n, input string tag);
        int guard;
        for (int k = 0; k < n; k++) begin
            guard = 0;
            tx_ready = 1'b1;
            while (!tx_valid && guard < 64) begin
                tick;
                guard++;
            end
            check($sformatf("%s_valid%0d", tag, k), 64'(tx_valid), 64'd1);
            check($sformatf("%s_data%0d", tag, k), tx_data, exp_w[k]);
            check($sformatf("%s_last%0d", tag, k), 64'(tx_last), 64'(k == n - 1));
            tick;
        end
        tx_ready = 1'b0;
    endtask

    task automatic send_rx(input int n, input string tag);
        int guard;
        for (int k = 0; k < n; k++) begin
            guard = 0;
            rx_valid = 1'b1;
            rx_data  = rx_w[k];
            rx_last  = rx_l[k];
            while (!rx_ready && guard < 64) begin
                tick;
                guard++;
            end
            check($sformatf("%s_ready%0d", tag, k), 64'(rx_ready), 64'd1);
            tick;
        end
        rx_valid = 1'b0;
        rx_last  = 1'b0;
        rx_data  = '0;
    endtask

    task automatic wait_end(input string tag, input logic exp_ok, output int n);
        n = 0;
        while (!(auth_ok || auth_fail) && n < 64) begin
            tick;
            n++;
        end
        check({tag, "_ok"}, 64'(auth_ok), 64'(exp_ok));
        check({tag, "_fail"}, 64'(auth_fail), 64'(!exp_ok));
        tick;
        check({tag, "_pulse_end"}, {62'd0, auth_ok, auth_fail}, 64'd0);
        check({tag, "_busy_clr"}, 64'(busy), 64'd0);
    endtask

    task automatic set_m1(input logic [63:0] n1_word);
        exp_w[0] = 64'hED34; exp_w[1] = n1_word; exp_w[2] = 64'hA55A;
    endtask

    task automatic set_m2;
        rx_w[0] = 64'h5A9F; rx_w[1] = 64'h5A2D; rx_w[2] = 64'h5A78; rx_w[3] = 64'h5A5B;
        rx_l[0] = 1'b0; rx_l[1] = 1'b0; rx_l[2] = 1'b0; rx_l[3] = 1'b1;
    endtask

    task automatic set_m3_m4(input logic [63:0] rsk_flip);
        exp_w[0] = 64'hED34; exp_w[1] = 64'hFF77; exp_w[2] = 64'h0BAD_0F0D;
        exp_w[3] = 64'hFF77; exp_w[4] = ki ^ 64'hFF00;
        rx_w[0] = 64'hC5 ^ ki; rx_w[1] = 64'h77 ^ ki; rx_w[2] = 64'h44 ^ ki;
        rx_w[3] = puf_m(64'h77) ^ rsk_flip ^ ki; rx_w[4] = 64'h99 ^ ki;
        for (int k = 0; k < 5; k++) rx_l[k] = (k == 4);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; tx_ready = 1'b0;
        rx_valid = 1'b0; rx_last = 1'b0; rx_data = '0;
        ev_psid = '0; ev_pub = '0; cs_pub = '0; ev_rs = '0;
        ki = puf_m(64'h1);
        repeat (3) tick;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_tx_valid", 64'(tx_valid), 64'd0);
        check("rst_rx_ready", 64'(rx_ready), 64'd0);
        check("rst_pulses", {62'd0, auth_ok, auth_fail}, 64'd0);
        check("rst_fail_code", 64'(fail_code), 64'd0);
        check("rst_session_key", session_key, 64'd0);
        rst_n = 1'b1;
        tick;
        check("rel_tx_valid", 64'(tx_valid), 64'd0);
        check("rel_rx_ready", 64'(rx_ready), 64'd0);

        // Session 1: stalled first word, ignored restart, then full success.
        do_start;
        ev_psid = 64'hDEAD;
        check("s1_busy", 64'(busy), 64'd1);
        check("s1_first_word", tx_data, 64'hED34);
        for (int i = 0; i < 10; i++) begin
            start = (i == 4);
            tick;
            check($sformatf("s1_stall%0d", i), tx_data, 64'hED34);
        end
        start = 1'b0;
        set_m1(64'hFF01);
        recv_tx(3, "s1_m1");
        check("s1_m1_done", 64'(tx_valid), 64'd0);
        check("s1_wait_m2", 64'(rx_ready), 64'd1);
        set_m2;
        send_rx(4, "s1_m2");
        set_m3_m4(64'd0);
        recv_tx(5, "s1_m3");
        ok_base = ok_cnt;
        send_rx(5, "s1_m4");
        wait_end("s1", 1'b1, cyc);
        check("s1_latency", 64'(cyc), 64'(OK_LAT));
        check("s1_ok_pulses", 64'(ok_cnt - ok_base), 64'd1);
        check("s1_fail_code", 64'(fail_code), 64'd0);
`ifdef AUTH_SESSION_KEY_EN
        check("s1_session_key", session_key, hash_m(ki, 64'h22, 64'h44, 64'h99));
`else
        check("s1_session_key", session_key, 64'd0);
`endif

        // Session 2: first M2 word lands on the timeout cycle; bad rsk.
        do_start;
        set_m1(64'hFF02);
        recv_tx(3, "s2_m1");
        repeat (15) tick;
        set_m2;
        send_rx(4, "s2_m2");
        check("s2_no_retx", 64'(tx_valid && tx_data == 64'hED34 && !tx_last), 64'd1);
        set_m3_m4(64'd1);
        recv_tx(5, "s2_m3");
        ok_base = ok_cnt;
        send_rx(5, "s2_m4");
        wait_end("s2", 1'b0, cyc);
        check("s2_fail_code", 64'(fail_code), 64'd2);
        check("s2_no_ok", 64'(ok_cnt - ok_base), 64'd0);
        repeat (3) tick;
        check("s2_code_held", 64'(fail_code), 64'd2);

        // Session 3: rx_last on the second M2 word.
        do_start;
        check("s3_code_cleared", 64'(fail_code), 64'd0);
        set_m1(64'hFF03);
        recv_tx(3, "s3_m1");
        set_m2;
        rx_l[1] = 1'b1;
        send_rx(2, "s3_m2");
        wait_end("s3", 1'b0, cyc);
        check("s3_fail_code", 64'(fail_code), 64'd3);

        // Session 4: no M2 at all -> one retransmission, then timeout.
        do_start;
        set_m1(64'hFF04);
        recv_tx(3, "s4_m1");
        cyc = 0;
        while (!tx_valid && !auth_fail && cyc < 100) begin
            cyc++;
            tick;
        end
        check("s4_retx_gap", 64'(cyc), 64'd16);
        recv_tx(3, "s4_m1_retx");
        cyc = 0;
        while (!tx_valid && !auth_fail && cyc < 100) begin
            cyc++;
            tick;
        end
        check("s4_fail_gap", 64'(cyc), 64'd16);
        check("s4_fail_pulse", 64'(auth_fail), 64'd1);
        check("s4_fail_code", 64'(fail_code), 64'd1);
        tick;

        // Session 5: reset held two cycles in the middle of WAIT_M2.
        do_start;
        set_m1(64'hFF05);
        recv_tx(3, "s5_m1");
        set_m2;
        send_rx(1, "s5_m2");
        ok_base = ok_cnt;
        fail_base = fail_cnt;
        rst_n = 1'b0;
        repeat (2) tick;
        check("s5_busy", 64'(busy), 64'd0);
        check("s5_rx_ready", 64'(rx_ready), 64'd0);
        check("s5_pulses", {62'd0, auth_ok, auth_fail}, 64'd0);
        check("s5_fail_code", 64'(fail_code), 64'd0);
        check("s5_session_key", session_key, 64'd0);
        rst_n = 1'b1;
        tick;
        check("s5_rel_tx_valid", 64'(tx_valid), 64'd0);
        check("s5_rel_rx_ready", 64'(rx_ready), 64'd0);
        repeat (4) tick;
        check("s5_no_pulse", 64'((ok_cnt - ok_base) + (fail_cnt - fail_base)), 64'd0);
        do_start;
        set_m1(64'hFF01);
        recv_tx(3, "s5_n1_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
